// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: access size codes, FSM states and
// WB/M control bit positions, plus the alignment rule used at issue time.
package mem_access_stage_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_READ      = 1;
    localparam int M_WRITE     = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Size code 11 is handled as a word, so any nonzero low bits are illegal for it.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            default: bad = |lane;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and memory (slave).
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [3:0]        mem_be_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
// Purely combinational; the store and load halves use independent size/lane inputs.
module mem_access_stage_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]        st_size,
    input  logic [1:0]        st_lane,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [3:0]        st_be,
    output logic [DATA_W-1:0] st_wdata_rep,
    input  logic [1:0]        ld_size,
    input  logic [1:0]        ld_lane,
    input  logic              ld_unsigned,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    function automatic logic [DATA_W-1:0] extend8(input logic [7:0] b, input logic uns);
        logic signed [7:0] sb;
        sb = b;
        return uns ? {24'h0, b} : {{24{sb[7]}}, sb};
    endfunction

    function automatic logic [DATA_W-1:0] extend16(input logic [15:0] h, input logic uns);
        logic signed [15:0] sh;
        sh = h;
        return uns ? {16'h0, h} : {{16{sh[15]}}, sh};
    endfunction

    always_comb begin
        st_be        = 4'b1111;
        st_wdata_rep = st_wdata;
        case (st_size)
            SZ_BYTE: begin
                st_be        = 4'b0001 << st_lane;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be        = st_lane[1] ? 4'b1100 : 4'b0011;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        case (ld_lane)
            2'd0:    byte_sel = ld_rdata[7:0];
            2'd1:    byte_sel = ld_rdata[15:8];
            2'd2:    byte_sel = ld_rdata[23:16];
            default: byte_sel = ld_rdata[31:24];
        endcase
        half_sel = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = extend8(byte_sel, ld_unsigned);
            SZ_HALF: ld_data = extend16(half_sel, ld_unsigned);
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a variable-latency req/ack bus, stalls the
// front of the pipe while an access is outstanding and bubbles MEM_WB meanwhile.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          WB_i,
    input  logic [1:0]          M_i,
    input  logic [1:0]          size_i,
    input  logic                unsigned_i,
    input  logic [DATA_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [4:0]          RDaddr_i,
    mem_access_stage_if.master  mem,
    output logic                stall_o,
    output logic [1:0]          WB_o,
    output logic [DATA_W-1:0]   data1_o,
    output logic [DATA_W-1:0]   data2_o,
    output logic [4:0]          RDaddr_o,
    output logic                misalign_o,
    output logic                timeout_o
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               latch_en, cap_en;

    logic               we_p1;
    logic [3:0]         be_p1;
    logic [DATA_W-1:2]  addr_p1;
    logic [DATA_W-1:0]  wdata_p1;
    logic [1:0]         size_p1;
    logic [1:0]         lane_p1;
    logic               uns_p1;
    logic [DATA_W-1:0]  load_p1;

    logic [3:0]         be_w;
    logic [DATA_W-1:0]  wdata_w;
    logic [DATA_W-1:0]  ld_data_w;

    mem_access_stage_lane_align u_align (
        .st_size      (size_i),
        .st_lane      (addr_i[1:0]),
        .st_wdata     (wdata_i),
        .st_be        (be_w),
        .st_wdata_rep (wdata_w),
        .ld_size      (size_p1),
        .ld_lane      (lane_p1),
        .ld_unsigned  (uns_p1),
        .ld_rdata     (mem.mem_rdata_i),
        .ld_data      (ld_data_w)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_o    = 1'b0;
        WB_o       = WB_i;
        misalign_o = 1'b0;
        timeout_o  = 1'b0;
        latch_en   = 1'b0;
        cap_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|M_i) begin
                    WB_o = 2'b00;
                    if (is_misaligned(size_i, addr_i[1:0])) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o  = 1'b1;
                        latch_en = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_o = 1'b1;
                WB_o    = 2'b00;
                cnt_d   = cnt_q + 1'b1;
                if (mem.mem_ack_i) begin
                    cap_en  = 1'b1;
                    state_d = ST_DONE;
                end else if (TIMEOUT != 0 && cnt_d == TIMEOUT_C) begin
                    // Abort releases the pipe this cycle; the instruction retires as a bubble.
                    timeout_o = 1'b1;
                    stall_o   = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state and architecturally visible registers: reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_p1   <= 1'b0;
            be_p1   <= 4'b0000;
            load_p1 <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                we_p1 <= M_i[M_WRITE] & ~M_i[M_READ];
                be_p1 <= be_w;
            end
            if (cap_en && !we_p1) begin
                load_p1 <= ld_data_w;
            end
        end
    end

    // Request payload: only meaningful while mem_req_o is high, so no reset.
    always_ff @(posedge clk_i) begin
        if (latch_en) begin
            addr_p1  <= addr_i[DATA_W-1:2];
            wdata_p1 <= wdata_w;
            size_p1  <= size_i;
            lane_p1  <= addr_i[1:0];
            uns_p1   <= unsigned_i;
        end
    end

    assign mem.mem_req_o   = (state_q == ST_REQ);
    assign mem.mem_we_o    = we_p1;
    assign mem.mem_addr_o  = {addr_p1, 2'b00};
    assign mem.mem_be_o    = be_p1;
    assign mem.mem_wdata_o = wdata_p1;

    assign data1_o  = load_p1;
    assign data2_o  = addr_i;
    assign RDaddr_o = RDaddr_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, loads/stores with lane handling,
// misalignment, timeout and reset during an outstanding request.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  WB_i, M_i, size_i;
    logic        unsigned_i;
    logic [31:0] addr_i, wdata_i;
    logic [4:0]  RDaddr_i;
    logic        stall_o, misalign_o, timeout_o;
    logic [1:0]  WB_o;
    logic [31:0] data1_o, data2_o;
    logic [4:0]  RDaddr_o;

    int checks = 0;
    int failures = 0;

    int          r_stalls;
    logic [31:0] r_d1, r_wd, r_addr;
    logic [1:0]  r_wb;
    logic [3:0]  r_be;
    logic        r_we;
    int          reqs;
    int          to_cycle;

    mem_access_stage_if bus();

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .WB_i       (WB_i),
        .M_i        (M_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .RDaddr_i   (RDaddr_i),
        .mem        (bus),
        .stall_o    (stall_o),
        .WB_o       (WB_o),
        .data1_o    (data1_o),
        .data2_o    (data2_o),
        .RDaddr_o   (RDaddr_o),
        .misalign_o (misalign_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] m, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wb);
        M_i = m; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd; WB_i = wb;
        RDaddr_i = 5'd7;
    endtask

    // Runs one aligned access to completion; ack arrives in the ack_after-th REQ cycle.
    task automatic run_access(input int ack_after, input logic [31:0] rdata);
        int   reqn;
        logic done;
        reqn = 0;
        done = 1'b0;
        r_stalls = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.mem_req_o) begin
                reqn++;
                if (reqn == 1) begin
                    r_be = bus.mem_be_o; r_wd = bus.mem_wdata_o;
                    r_we = bus.mem_we_o; r_addr = bus.mem_addr_o;
                end
                bus.mem_ack_i   = (reqn == ack_after);
                bus.mem_rdata_i = rdata;
            end
            @(negedge clk);
            if (stall_o) r_stalls++;
            else begin
                r_d1 = data1_o; r_wb = WB_o; done = 1'b1;
            end
            next_cycle();
            bus.mem_ack_i = 1'b0;
        end
        check_eq("access_done", {31'b0, done}, 32'd1);
        M_i = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = 32'h0;
        set_op(2'b00, 2'b10, 1'b0, 32'h0, 32'h0, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req",   {31'b0, bus.mem_req_o}, 32'd0);
        check_eq("rst_we",    {31'b0, bus.mem_we_o}, 32'd0);
        check_eq("rst_be",    {28'b0, bus.mem_be_o}, 32'd0);
        check_eq("rst_stall", {31'b0, stall_o}, 32'd0);
        check_eq("rst_data1", data1_o, 32'h0);
        check_eq("rst_flags", {30'b0, misalign_o, timeout_o}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Non-memory op passes straight through
        set_op(2'b00, 2'b10, 1'b0, 32'h10, 32'h0, 2'b10);
        @(negedge clk);
        check_eq("add_wb",    {30'b0, WB_o}, 32'd2);
        check_eq("add_data2", data2_o, 32'h10);
        check_eq("add_stall", {31'b0, stall_o}, 32'd0);
        check_eq("add_req",   {31'b0, bus.mem_req_o}, 32'd0);
        check_eq("add_rd",    {27'b0, RDaddr_o}, 32'd7);
        next_cycle();

        set_op(2'b10, 2'b10, 1'b0, 32'h100, 32'h0, 2'b11);
        run_access(3, 32'hDEAD_BEEF);
        check_eq("lw_stalls", r_stalls, 32'd4);
        check_eq("lw_data1",  r_d1, 32'hDEAD_BEEF);
        check_eq("lw_wb",     {30'b0, r_wb}, 32'd3);
        check_eq("lw_be",     {28'b0, r_be}, 32'hF);
        check_eq("lw_we",     {31'b0, r_we}, 32'd0);
        check_eq("lw_addr",   r_addr, 32'h100);

        set_op(2'b10, 2'b00, 1'b0, 32'h103, 32'h0, 2'b11);
        run_access(1, 32'h80FF_FF00);
        check_eq("lb_data1",  r_d1, 32'hFFFF_FF80);
        check_eq("lb_stalls", r_stalls, 32'd2);
        check_eq("lb_addr",   r_addr, 32'h100);

        set_op(2'b10, 2'b00, 1'b1, 32'h103, 32'h0, 2'b11);
        run_access(1, 32'h80FF_FF00);
        check_eq("lbu_data1", r_d1, 32'h0000_0080);

        set_op(2'b10, 2'b01, 1'b0, 32'h102, 32'h0, 2'b11);
        run_access(2, 32'h80FF_FF00);
        check_eq("lh_data1",  r_d1, 32'hFFFF_80FF);

        set_op(2'b10, 2'b01, 1'b1, 32'h100, 32'h0, 2'b11);
        run_access(1, 32'h1234_ABCD);
        check_eq("lhu_data1", r_d1, 32'h0000_ABCD);

        set_op(2'b01, 2'b01, 1'b0, 32'h102, 32'h1234_ABCD, 2'b00);
        run_access(1, 32'hFFFF_FFFF);
        check_eq("sh_be",     {28'b0, r_be}, 32'hC);
        check_eq("sh_wdata",  r_wd, 32'hABCD_ABCD);
        check_eq("sh_we",     {31'b0, r_we}, 32'd1);
        check_eq("sh_keep",   r_d1, 32'h0000_ABCD);

        set_op(2'b01, 2'b00, 1'b0, 32'h101, 32'h0000_0077, 2'b00);
        run_access(1, 32'h0);
        check_eq("sb_be",     {28'b0, r_be}, 32'h2);
        check_eq("sb_wdata",  r_wd, 32'h7777_7777);

        set_op(2'b01, 2'b10, 1'b0, 32'h104, 32'hCAFE_F00D, 2'b00);
        run_access(2, 32'h0);
        check_eq("sw_be",     {28'b0, r_be}, 32'hF);
        check_eq("sw_wdata",  r_wd, 32'hCAFE_F00D);
        check_eq("sw_addr",   r_addr, 32'h104);
        check_eq("sw_keep",   r_d1, 32'h0000_ABCD);

        // Misaligned word load is dropped without a request
        set_op(2'b10, 2'b10, 1'b0, 32'h101, 32'h0, 2'b11);
        @(negedge clk);
        check_eq("mis_pulse", {31'b0, misalign_o}, 32'd1);
        check_eq("mis_stall", {31'b0, stall_o}, 32'd0);
        check_eq("mis_wb",    {30'b0, WB_o}, 32'd0);
        M_i = 2'b00;
        next_cycle();
        @(negedge clk);
        check_eq("mis_noreq", {31'b0, bus.mem_req_o}, 32'd0);
        check_eq("mis_clear", {31'b0, misalign_o}, 32'd0);
        next_cycle();

        // No ack: abort after TIMEOUT request cycles
        set_op(2'b10, 2'b10, 1'b0, 32'h200, 32'h0, 2'b11);
        reqs = 0;
        to_cycle = -1;
        @(negedge clk);
        check_eq("to_issue_stall", {31'b0, stall_o}, 32'd1);
        next_cycle();
        for (int i = 0; i < 10 && to_cycle < 0; i++) begin
            if (bus.mem_req_o) reqs++;
            @(negedge clk);
            if (timeout_o) begin
                to_cycle = reqs;
                check_eq("to_stall", {31'b0, stall_o}, 32'd0);
                check_eq("to_wb",    {30'b0, WB_o}, 32'd0);
                M_i = 2'b00;
            end
            next_cycle();
        end
        check_eq("to_req_cycles", to_cycle, 32'd4);
        @(negedge clk);
        check_eq("to_req_drop", {31'b0, bus.mem_req_o}, 32'd0);
        check_eq("to_clear",    {31'b0, timeout_o}, 32'd0);
        next_cycle();

        // Reset while a request is outstanding, then a stray ack
        set_op(2'b10, 2'b10, 1'b0, 32'h300, 32'h0, 2'b11);
        next_cycle();
        @(negedge clk);
        check_eq("rr_req_up", {31'b0, bus.mem_req_o}, 32'd1);
        next_cycle();
        rst = 1'b1;
        M_i = 2'b00;
        next_cycle();
        @(negedge clk);
        check_eq("rr_req_drop", {31'b0, bus.mem_req_o}, 32'd0);
        check_eq("rr_stall",    {31'b0, stall_o}, 32'd0);
        next_cycle();
        rst = 1'b0;
        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = 32'h5555_5555;
        @(negedge clk);
        check_eq("stray_stall", {31'b0, stall_o}, 32'd0);
        next_cycle();
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        check_eq("stray_data1", data1_o, 32'h0);
        check_eq("stray_req",   {31'b0, bus.mem_req_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
